// File: rtl/ks_add_sched.sv
// Round-robin issue scheduler for a shared pipelined Kogge-Stone adder.
// Grants one requester per cycle, registers its operands toward the adder,
// follows each operation with a requester tag through a pipeline matched to
// the adder latency, and routes the sum/carry back as a one-hot response.
module ks_add_sched #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 32,
    parameter int LAT   = 7
) (
    input  logic                  i_clk,
    input  logic                  i_rstn,
    input  logic [NREQ-1:0]       i_req_vld,
    output logic [NREQ-1:0]       o_req_rdy,
    input  logic [NREQ*WIDTH-1:0] i_req_a,
    input  logic [NREQ*WIDTH-1:0] i_req_b,
    input  logic [NREQ-1:0]       i_req_c0,
    input  logic                  i_hold,
    output logic                  o_add_vld,
    output logic [WIDTH-1:0]      o_add_a,
    output logic [WIDTH-1:0]      o_add_b,
    output logic                  o_add_c0,
    input  logic [WIDTH-1:0]      i_add_sum,
    input  logic                  i_add_cout,
    output logic [NREQ-1:0]       o_rsp_vld,
    output logic [WIDTH-1:0]      o_rsp_sum,
    output logic                  o_rsp_cout,
    output logic                  o_idle
);

    localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1;

    logic [IDW-1:0]         ptr_q, ptr_d;
    logic [IDW-1:0]         gnt_id;
    logic                   gnt_any;
    logic                   xfer;

    logic                   add_vld_q, add_vld_d;
    logic [WIDTH-1:0]       add_a_q, add_a_d;
    logic [WIDTH-1:0]       add_b_q, add_b_d;
    logic                   add_c0_q, add_c0_d;

    // Stage j holds the tag of the operation whose operands were issued j
    // cycles ago; stage LAT lines up with the adder's sum output.
    logic [LAT:0]           vld_pipe_q;
    logic [LAT:0][IDW-1:0]  id_pipe_q;

    logic [NREQ-1:0]        rsp_vld_q, rsp_vld_d;
    logic [WIDTH-1:0]       rsp_sum_q, rsp_sum_d;
    logic                   rsp_cout_q, rsp_cout_d;

    // Round-robin search starting at ptr; first valid requester wins.
    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = ptr_q;
        for (int i = 0; i < NREQ; i++) begin
            if (!gnt_any && i_req_vld[(int'(ptr_q) + i) % NREQ]) begin
                gnt_any = 1'b1;
                gnt_id  = IDW'((int'(ptr_q) + i) % NREQ);
            end
        end
    end

    assign xfer = gnt_any & ~i_hold;

    // One-hot grant, suppressed while issue is held.
    always_comb begin
        o_req_rdy = '0;
        if (xfer) o_req_rdy[gnt_id] = 1'b1;
    end

    // Issue path: pointer advance and operand capture on a transfer.
    always_comb begin
        ptr_d     = ptr_q;
        add_vld_d = xfer;
        add_a_d   = add_a_q;
        add_b_d   = add_b_q;
        add_c0_d  = add_c0_q;
        if (xfer) begin
            ptr_d    = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + 1'b1;
            add_a_d  = i_req_a[gnt_id*WIDTH +: WIDTH];
            add_b_d  = i_req_b[gnt_id*WIDTH +: WIDTH];
            add_c0_d = i_req_c0[gnt_id];
        end
    end

    // Return path: a valid tag at the adder-aligned stage captures the result.
    always_comb begin
        rsp_vld_d  = '0;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        if (vld_pipe_q[LAT]) begin
            rsp_vld_d  = NREQ'(1) << id_pipe_q[LAT];
            rsp_sum_d  = i_add_sum;
            rsp_cout_d = i_add_cout;
        end
    end

    // State registers with synchronous active-low reset; reset drops all
    // in-flight tags so late adder outputs produce no response.
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            ptr_q      <= '0;
            add_vld_q  <= 1'b0;
            add_a_q    <= '0;
            add_b_q    <= '0;
            add_c0_q   <= 1'b0;
            vld_pipe_q <= '0;
            id_pipe_q  <= '0;
            rsp_vld_q  <= '0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
        end else begin
            ptr_q      <= ptr_d;
            add_vld_q  <= add_vld_d;
            add_a_q    <= add_a_d;
            add_b_q    <= add_b_d;
            add_c0_q   <= add_c0_d;
            vld_pipe_q <= {vld_pipe_q[LAT-1:0], xfer};
            id_pipe_q  <= {id_pipe_q[LAT-1:0], gnt_id};
            rsp_vld_q  <= rsp_vld_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
        end
    end

    assign o_add_vld  = add_vld_q;
    assign o_add_a    = add_a_q;
    assign o_add_b    = add_b_q;
    assign o_add_c0   = add_c0_q;
    assign o_rsp_vld  = rsp_vld_q;
    assign o_rsp_sum  = rsp_sum_q;
    assign o_rsp_cout = rsp_cout_q;
    assign o_idle     = ~add_vld_q & ~|vld_pipe_q & ~|rsp_vld_q;

endmodule

// File: tb/tb_ks_add_sched.sv
// Directed bench for ks_add_sched with a LAT-deep adder stand-in.
module tb_ks_add_sched;

    localparam int NREQ  = 4;
    localparam int WIDTH = 32;
    localparam int LAT   = 7;
    localparam int NCYC  = 1024;

    logic                  i_clk = 1'b0;
    logic                  i_rstn;
    logic [NREQ-1:0]       i_req_vld;
    logic [NREQ-1:0]       o_req_rdy;
    logic [NREQ*WIDTH-1:0] i_req_a, i_req_b;
    logic [NREQ-1:0]       i_req_c0;
    logic                  i_hold;
    logic                  o_add_vld;
    logic [WIDTH-1:0]      o_add_a, o_add_b;
    logic                  o_add_c0;
    logic [WIDTH-1:0]      i_add_sum;
    logic                  i_add_cout;
    logic [NREQ-1:0]       o_rsp_vld;
    logic [WIDTH-1:0]      o_rsp_sum;
    logic                  o_rsp_cout;
    logic                  o_idle;

    ks_add_sched #(.NREQ(NREQ), .WIDTH(WIDTH), .LAT(LAT)) dut (
        .i_clk(i_clk), .i_rstn(i_rstn), .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy),
        .i_req_a(i_req_a), .i_req_b(i_req_b), .i_req_c0(i_req_c0), .i_hold(i_hold),
        .o_add_vld(o_add_vld), .o_add_a(o_add_a), .o_add_b(o_add_b), .o_add_c0(o_add_c0),
        .i_add_sum(i_add_sum), .i_add_cout(i_add_cout), .o_rsp_vld(o_rsp_vld),
        .o_rsp_sum(o_rsp_sum), .o_rsp_cout(o_rsp_cout), .o_idle(o_idle)
    );

    always #5 i_clk = ~i_clk;

    // Adder stand-in: samples the registered operands, result LAT cycles later.
    logic [WIDTH:0] apipe [0:LAT-1];
    always @(posedge i_clk) begin
        apipe[0] <= {1'b0, o_add_a} + {1'b0, o_add_b} + {{WIDTH{1'b0}}, o_add_c0};
        for (int j = 1; j < LAT; j++) apipe[j] <= apipe[j-1];
    end
    assign i_add_sum  = apipe[LAT-1][WIDTH-1:0];
    assign i_add_cout = apipe[LAT-1][WIDTH];

    int n_cmp = 0, n_err = 0, cyc = 0, last_iss, due;
    logic [WIDTH-1:0] opa [NREQ], opb [NREQ];
    logic             opc [NREQ];
    logic             exp_avld [NCYC];
    logic [WIDTH-1:0] exp_a [NCYC], exp_b [NCYC], exp_sum [NCYC];
    logic             exp_c [NCYC], exp_cout [NCYC];
    logic [NREQ-1:0]  exp_rvld [NCYC];

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d: observed %0h expected %0h", tag, cyc, obs, exp);
        end
    endtask

    task automatic drive_ops();
        for (int k = 0; k < NREQ; k++) begin
            i_req_a[k*WIDTH +: WIDTH] = opa[k];
            i_req_b[k*WIDTH +: WIDTH] = opb[k];
            i_req_c0[k]               = opc[k];
        end
    endtask

    // Advance one edge, then compare registered outputs to the expectation tables.
    task automatic tick();
        @(posedge i_clk);
        cyc++;
        #1;
        chk("add_vld", {63'd0, o_add_vld}, {63'd0, exp_avld[cyc]});
        if (exp_avld[cyc]) begin
            chk("add_a",  {32'd0, o_add_a},  {32'd0, exp_a[cyc]});
            chk("add_b",  {32'd0, o_add_b},  {32'd0, exp_b[cyc]});
            chk("add_c0", {63'd0, o_add_c0}, {63'd0, exp_c[cyc]});
        end
        chk("rsp_vld", {60'd0, o_rsp_vld}, {60'd0, exp_rvld[cyc]});
        if (exp_rvld[cyc] != '0) begin
            chk("rsp_sum",  {32'd0, o_rsp_sum},  {32'd0, exp_sum[cyc]});
            chk("rsp_cout", {63'd0, o_rsp_cout}, {63'd0, exp_cout[cyc]});
        end
    endtask

    // Expect requester k to be granted this cycle; book issue and response.
    task automatic expect_gnt(input int k);
        logic [WIDTH:0] s;
        logic [NREQ-1:0] oh;
        oh = '0;
        oh[k] = 1'b1;
        #1;
        chk("rdy", {60'd0, o_req_rdy}, {60'd0, oh});
        s = {1'b0, opa[k]} + {1'b0, opb[k]} + {{WIDTH{1'b0}}, opc[k]};
        exp_avld[cyc+1] = 1'b1;
        exp_a[cyc+1]    = opa[k];
        exp_b[cyc+1]    = opb[k];
        exp_c[cyc+1]    = opc[k];
        exp_rvld[cyc+LAT+2] = oh;
        exp_sum[cyc+LAT+2]  = s[WIDTH-1:0];
        exp_cout[cyc+LAT+2] = s[WIDTH];
        tick();
    endtask

    initial begin
        for (int i = 0; i < NCYC; i++) begin
            exp_avld[i] = 1'b0; exp_rvld[i] = '0;
        end
        for (int k = 0; k < NREQ; k++) begin
            opa[k] = 32'h1000_0000 * k + 32'h11 * k + 32'h5;
            opb[k] = 32'h0100_0003 + k;
            opc[k] = k[0];
        end
        drive_ops();
        i_rstn = 1'b0; i_hold = 1'b0; i_req_vld = '1;

        // Reset held 3 cycles with every request valid.
        repeat (3) begin
            tick();
            chk("idle_rst", {63'd0, o_idle}, 64'd1);
        end
        i_rstn = 1'b1;
        expect_gnt(0);

        // Single add from requester 2 with full carry propagation.
        opa[2] = 32'hFFFF_FFFF; opb[2] = 32'h0000_0001; opc[2] = 1'b0;
        drive_ops();
        i_req_vld = 4'b0100;
        expect_gnt(2);
        due = cyc + LAT + 1;
        i_req_vld = '0;
        #1 chk("rdy_none", {60'd0, o_req_rdy}, 64'd0);
        while (cyc < due) tick();
        chk("single_vld",  {60'd0, o_rsp_vld},  64'h4);
        chk("single_sum",  {32'd0, o_rsp_sum},  64'h0);
        chk("single_cout", {63'd0, o_rsp_cout}, 64'h1);
        tick();
        chk("idle_single", {63'd0, o_idle}, 64'd1);

        // Sparse wrap: ptr sits at 3, only requesters 1 and 3 valid.
        i_req_vld = 4'b1010;
        expect_gnt(3);
        expect_gnt(1);
        expect_gnt(3);

        // Fairness: all valid, strict rotation, 14 grants leave ptr at 2.
        for (int k = 0; k < NREQ; k++) begin
            opa[k] = 32'h8000_0000 + 32'h100 * k;
            opb[k] = 32'h7FFF_FF00 + 32'h7 * k;
            opc[k] = k[1];
        end
        drive_ops();
        i_req_vld = '1;
        for (int g = 0; g < 14; g++) expect_gnt(g % NREQ);
        last_iss = cyc;

        // Hold: no grants, in-flight responses still arrive, idle after drain.
        i_hold = 1'b1;
        for (int h = 0; h < 10; h++) begin
            #1 chk("rdy_hold", {60'd0, o_req_rdy}, 64'd0);
            tick();
            chk("idle_hold", {63'd0, o_idle}, {63'd0, (cyc - last_iss) >= LAT + 2});
        end
        i_hold = 1'b0;
        expect_gnt(2);
        expect_gnt(3);

        // Reset mid-flight: four adds then a one-cycle reset pulse.
        expect_gnt(0);
        expect_gnt(1);
        expect_gnt(2);
        expect_gnt(3);
        for (int i = cyc + 1; i < NCYC; i++) begin
            exp_avld[i] = 1'b0; exp_rvld[i] = '0;
        end
        i_rstn = 1'b0;
        tick();
        i_rstn = 1'b1; i_req_vld = '0;
        repeat (12) begin
            tick();
            chk("idle_post_rst", {63'd0, o_idle}, 64'd1);
        end
        i_req_vld = '1;
        expect_gnt(0);
        i_req_vld = '0;
        repeat (LAT + 2) tick();
        chk("idle_end", {63'd0, o_idle}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
